// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bundle for the load/store unit
interface load_store_unit_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    // Seen from the load/store unit itself
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_din
    );

    // Seen from the processor port and the data memory together
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load/store adapter onto a word-wide synchronous RAM
module load_store_unit #(
    parameter int ADDR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave lsu
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        lane_q, lane_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic        accept;
    logic        illegal;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [31:0] resp_data;

    // Upper address bits only select beyond the RAM, so the word index wraps
    logic unused_addr_hi;
    assign unused_addr_hi = ^lsu.req_addr[31:ADDR_W+2];

    // Accept decode and alignment check on the live request
    always_comb begin
        accept  = lsu.req_valid && (state_q == S_IDLE);
        illegal = (lsu.req_size == 2'b11)
               || ((lsu.req_size == SZ_HALF) && lsu.req_addr[0])
               || ((lsu.req_size == SZ_WORD) && (lsu.req_addr[1:0] != 2'b00));
    end

    // Lane extraction with sign/zero extension, and lane insertion for sub-word stores
    always_comb begin
        shifted   = lsu.mem_dout >> {lane_q, 3'b000};
        load_data = lsu.mem_dout;
        merged    = lsu.mem_dout;
        case (size_q)
            SZ_BYTE: begin
                load_data = unsigned_q ? {24'h000000, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
                merged[{lane_q, 3'b000} +: 8] = mem_din_q[7:0];
            end
            SZ_HALF: begin
                load_data = unsigned_q ? {16'h0000, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
                merged[{lane_q[1], 4'b0000} +: 16] = mem_din_q[15:0];
            end
            default: begin
                load_data = lsu.mem_dout;
                merged    = lsu.mem_dout;
            end
        endcase
        // Only a successful load returns data; stores and errors report zero
        resp_data = (!we_q && !err_q) ? load_data : 32'h0;
    end

    // Next-state and register-update logic for the access sequence
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        lane_d      = lane_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d       = lsu.req_we;
                    size_d     = lsu.req_size;
                    unsigned_d = lsu.req_unsigned;
                    lane_d     = lsu.req_addr[1:0];
                    err_d      = illegal;
                    if (illegal) begin
                        // Rejected requests leave the memory-side signals untouched
                        state_d = S_RESP;
                    end else begin
                        mem_addr_d = lsu.req_addr[ADDR_W+1:2];
                        // Store data parks in mem_din until MERGE or WRITE uses it
                        mem_din_d  = lsu.req_wdata;
                        state_d    = (lsu.req_we && (lsu.req_size == SZ_WORD)) ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = we_q ? S_MERGE : S_RESP;
            end
            S_MERGE: begin
                mem_din_d = merged;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_rdata_d = resp_data;
                rsp_err_d   = err_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            lane_q      <= 2'b00;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            lane_q      <= lane_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Load data only exists on mem_dout during RESP, so the response is
    // presented live in that cycle and held from the registers afterwards
    always_comb begin
        lsu.req_ready = (state_q == S_IDLE);
        lsu.rsp_valid = (state_q == S_RESP);
        lsu.rsp_rdata = (state_q == S_RESP) ? resp_data : rsp_rdata_q;
        lsu.rsp_err   = (state_q == S_RESP) ? err_q : rsp_err_q;
        lsu.mem_we    = (state_q == S_WRITE);
        lsu.mem_addr  = mem_addr_q;
        lsu.mem_din   = mem_din_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam int ADDR_W = 9;

    logic clk;
    logic rst;

    load_store_unit_if #(.ADDR_W(ADDR_W)) lsu ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (lsu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide RAM with synchronous read, plus a write-pulse log
    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    int                we_count = 0;
    logic [ADDR_W-1:0] last_widx;
    always @(posedge clk) begin
        if (lsu.mem_we) begin
            ram[lsu.mem_addr] <= lsu.mem_din;
            we_count          <= we_count + 1;
            last_widx         <= lsu.mem_addr;
        end
        lsu.mem_dout <= ram[lsu.mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE; lat counts cycles from the accept edge to rsp_valid (0 = timeout)
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        lsu.req_we       = we;
        lsu.req_size     = size;
        lsu.req_unsigned = uns;
        lsu.req_addr     = addr;
        lsu.req_wdata    = wdata;
        lsu.req_valid    = 1'b1;
        lat   = 0;
        rdata = 32'hxxxxxxxx;
        err   = 1'bx;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) lsu.req_valid = 1'b0;
            if (lsu.rsp_valid) begin
                lat   = i;
                rdata = lsu.rsp_rdata;
                err   = lsu.rsp_err;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          w0;

    logic [31:0] bad_addr [3] = '{32'h6, 32'h1, 32'h0};
    logic [1:0]  bad_size [3] = '{2'b10, 2'b01, 2'b11};
    logic        bad_we   [3] = '{1'b0, 1'b1, 1'b0};

    logic [31:0] b2b_addr [3] = '{32'h0, 32'h10, 32'h14};
    logic [31:0] b2b_exp  [3] = '{32'hBEEF7FFF, 32'hDEADBEEF, 32'hCAFEF00D};

    initial begin
        rst              = 1'b0;
        lsu.req_valid    = 1'b0;
        lsu.req_we       = 1'b0;
        lsu.req_size     = 2'b00;
        lsu.req_unsigned = 1'b0;
        lsu.req_addr     = 32'h0;
        lsu.req_wdata    = 32'h0;
        #12;
        check("rst_req_ready", {31'h0, lsu.req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h0);
        check("rst_rsp_rdata", lsu.rsp_rdata, 32'h0);
        check("rst_mem_we",    {31'h0, lsu.mem_we}, 32'h0);
        check("rst_mem_addr",  {23'h0, lsu.mem_addr}, 32'h0);
        check("rst_mem_din",   lsu.mem_din, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 1: word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("sw_lat",     lat, 2);
        check("sw_rdata",   rd, 32'h0);
        check("sw_wecount", we_count, 1);
        check("sw_widx",    {23'h0, last_widx}, 32'h4);
        check("sw_ram",     ram[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("lw_lat",   lat, 2);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err",   {31'h0, er}, 32'h0);
        @(negedge clk);
        check("lw_hold",  lsu.rsp_rdata, 32'hDEADBEEF);

        // 2: byte store by read-modify-write, signed and unsigned byte loads
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, rd, er, lat);
        w0 = we_count;
        do_req(1'b1, 2'b00, 1'b0, 32'h2, 32'h123456AA, rd, er, lat);
        check("sb_lat",     lat, 4);
        check("sb_wecount", we_count, w0 + 1);
        check("sb_ram",     ram[0], 32'h11AA3344);
        do_req(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, rd, er, lat);
        check("lb_rdata",  rd, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, rd, er, lat);
        check("lbu_rdata", rd, 32'h000000AA);

        // 3: halfword loads both lanes, halfword store upper lane
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h80017FFF, rd, er, lat);
        do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, rd, er, lat);
        check("lh_rdata",  rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h0, 32'h0, rd, er, lat);
        check("lhu_rdata", rd, 32'h00007FFF);
        do_req(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000BEEF, rd, er, lat);
        check("sh_lat", lat, 4);
        check("sh_ram", ram[0], 32'hBEEF7FFF);

        // Upper address bits are ignored: 0x814 aliases word 5
        do_req(1'b1, 2'b10, 1'b0, 32'h814, 32'hCAFEF00D, rd, er, lat);
        check("wrap_widx", {23'h0, last_widx}, 32'h5);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
        check("wrap_lw", rd, 32'hCAFEF00D);

        // 4: misaligned word, misaligned half store, illegal size
        w0 = we_count;
        for (int i = 0; i < 3; i++) begin
            do_req(bad_we[i], bad_size[i], 1'b0, bad_addr[i], 32'h55555555, rd, er, lat);
            check($sformatf("err%0d_lat", i),   lat, 1);
            check($sformatf("err%0d_err", i),   {31'h0, er}, 32'h1);
            check($sformatf("err%0d_rdata", i), rd, 32'h0);
        end
        check("err_wecount", we_count, w0);
        check("err_ram0",    ram[0], 32'hBEEF7FFF);
        @(negedge clk);
        check("err_hold", {31'h0, lsu.rsp_err}, 32'h1);

        // 5: reset asserted during the MERGE cycle of a byte store
        w0 = we_count;
        @(negedge clk);
        lsu.req_we    = 1'b1;
        lsu.req_size  = 2'b00;
        lsu.req_addr  = 32'h1;
        lsu.req_wdata = 32'h00000012;
        lsu.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lsu.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_req_ready", {31'h0, lsu.req_ready}, 32'h1);
        check("arst_mem_we",    {31'h0, lsu.mem_we}, 32'h0);
        check("arst_mem_din",   lsu.mem_din, 32'h0);
        check("arst_mem_addr",  {23'h0, lsu.mem_addr}, 32'h0);
        check("arst_rsp_err",   {31'h0, lsu.rsp_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("arst_wecount", we_count, w0);
        check("arst_ram0",    ram[0], 32'hBEEF7FFF);
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
        check("arst_lw", rd, 32'hBEEF7FFF);

        // 6: req_valid held high across three loads
        begin
            int  idx  = 0;
            int  nrsp = 0;
            logic pend;
            @(negedge clk);
            lsu.req_we       = 1'b0;
            lsu.req_size     = 2'b10;
            lsu.req_unsigned = 1'b0;
            lsu.req_addr     = b2b_addr[0];
            lsu.req_valid    = 1'b1;
            pend = lsu.req_valid && lsu.req_ready;
            for (int c = 0; c < 30 && nrsp < 3; c++) begin
                @(negedge clk);
                if (pend) begin
                    idx++;
                    if (idx < 3) lsu.req_addr = b2b_addr[idx];
                    else lsu.req_valid = 1'b0;
                end
                if (lsu.rsp_valid) begin
                    check($sformatf("b2b%0d_ready", nrsp), {31'h0, lsu.req_ready}, 32'h0);
                    check($sformatf("b2b%0d_rdata", nrsp), lsu.rsp_rdata, b2b_exp[nrsp]);
                    nrsp++;
                end else if (!lsu.req_ready) begin
                    check("b2b_read_ready", {31'h0, lsu.req_ready}, 32'h0);
                end
                pend = lsu.req_valid && lsu.req_ready;
            end
            check("b2b_count", nrsp, 3);
            lsu.req_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
